// File: rtl/slave_tx_serializer_if.sv
// Handshake and serial-output bundle for slave_tx_serializer.
// The slave modport is the serializer side; the master modport is the core/bus side.
interface slave_tx_serializer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] data_input;
    logic                  s_ready;
    logic                  m_ready;
    logic                  tx_data;
    logic                  tx_valid;
    logic                  s_tx_done;
    logic                  busy;

    modport slave (
        input  s_valid, data_input, m_ready,
        output s_ready, tx_data, tx_valid, s_tx_done, busy
    );

    modport master (
        output s_valid, data_input, m_ready,
        input  s_ready, tx_data, tx_valid, s_tx_done, busy
    );
endinterface

// File: rtl/slave_tx_serializer.sv
// Slave-side serial transmit port: buffers parallel words in a small FIFO and shifts
// each one out a bit per clock, back-to-back with no idle gap between words.
// Optional feature: define SLAVE_TX_PARITY_EN to append an even-parity bit to every word.
module slave_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input logic                  clk,
    input logic                  rst,
    slave_tx_serializer_if.slave bus
);
    localparam int unsigned CntW  = $clog2(DATA_WIDTH);
    localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
    localparam logic [CntW-1:0]  LastBit   = CntW'(DATA_WIDTH - 1);
    localparam logic [CntW-1:0]  PenultBit = CntW'(DATA_WIDTH - 2);
    localparam logic [AddrW:0]   FullCount = (AddrW + 1)'(FIFO_DEPTH);

`ifdef SLAVE_TX_PARITY_EN
    localparam bit ParityEn = 1'b1;
    typedef enum logic [1:0] {StIdle, StData, StParity} state_e;
`else
    localparam bit ParityEn = 1'b0;
    typedef enum logic [0:0] {StIdle, StData} state_e;
`endif

    state_e                state_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CntW-1:0]       bit_cnt_q;
    logic                  tx_data_q;
    logic                  tx_valid_q;
    logic                  done_q;
`ifdef SLAVE_TX_PARITY_EN
    logic                  parity_q;
`endif

    // FIFO storage; pointers carry one extra bit to tell full from empty.
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AddrW:0]        wr_ptr_q, rd_ptr_q;
    logic [AddrW:0]        count;
    logic                  fifo_empty, fifo_full;
    logic                  push, pop, word_end;
    logic [DATA_WIDTH-1:0] head;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FullCount);
    assign head       = mem_q[rd_ptr_q[AddrW-1:0]];

    // s_ready looks only at registered occupancy, so a same-cycle pop never frees a slot.
    assign bus.s_ready = !fifo_full && !rst;
    assign push        = bus.s_valid && bus.s_ready;

`ifdef SLAVE_TX_PARITY_EN
    assign word_end = (state_q == StParity);
`else
    assign word_end = (state_q == StData) && (bit_cnt_q == LastBit);
`endif

    // m_ready only matters when a new word could start.
    assign pop = !fifo_empty && bus.m_ready && ((state_q == StIdle) || word_end);

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.s_tx_done = done_q;
    assign bus.busy      = (state_q != StIdle) || !fifo_empty;

    // FIFO pointer update; push and pop in the same cycle leave occupancy unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // FIFO data array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= bus.data_input;
    end

    // Transmit FSM with registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            tx_data_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef SLAVE_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else if (pop) begin
            // Load the next word and drive its first bit immediately.
            state_q    <= StData;
            bit_cnt_q  <= '0;
            tx_valid_q <= 1'b1;
            done_q     <= 1'b0;
            if (MSB_FIRST) begin
                tx_data_q <= head[DATA_WIDTH-1];
                shift_q   <= head << 1;
            end else begin
                tx_data_q <= head[0];
                shift_q   <= head >> 1;
            end
`ifdef SLAVE_TX_PARITY_EN
            parity_q   <= ^head;
`endif
        end else begin
            case (state_q)
                StData: begin
                    if (bit_cnt_q == LastBit) begin
`ifdef SLAVE_TX_PARITY_EN
                        state_q   <= StParity;
                        tx_data_q <= parity_q;
                        done_q    <= 1'b1;
`else
                        state_q    <= StIdle;
                        tx_data_q  <= 1'b0;
                        tx_valid_q <= 1'b0;
                        done_q     <= 1'b0;
`endif
                    end else begin
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        done_q    <= !ParityEn && (bit_cnt_q == PenultBit);
                        if (MSB_FIRST) begin
                            tx_data_q <= shift_q[DATA_WIDTH-1];
                            shift_q   <= shift_q << 1;
                        end else begin
                            tx_data_q <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                end
                default: begin
                    // Idle, or parity bit finished with nothing to start: line held low.
                    state_q    <= StIdle;
                    tx_data_q  <= 1'b0;
                    tx_valid_q <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end
endmodule
